controle_mag_pot: RTL and testbench

Second-generation magnetron controller for the microwave. It replaces the purely combinational set/reset control with a clocked FSM that has cook/pause/done states and edge-detected start. Magnetron power is selectable: `mag_on` is duty-cycle modulated over a parametrised period. The compatibility `set` and `reset` pulses are kept, so the existing magnetron SR-latch path can still be driven.

---
 rtl/controle_mag_pot.sv | 141 ++++++++++++++
 tb/tb_controle_mag_pot.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_mag_pot.sv
// Magnetron controller: clocked cook/pause/done FSM with edge-detected start,
// duty-cycle modulated mag_on and legacy set/reset pulses for the SR-latch path.
module controle_mag_pot #(
  parameter int PWR_W     = 4,
  parameter int CYCLE_LEN = 10,
  parameter int DONE_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [PWR_W-1:0] pwr_level,
  output logic             mag_on,
  output logic             set,
  output logic             reset,
  output logic [1:0]       state,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOKING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CNT_W  = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
  localparam int LVL_W  = $clog2(CYCLE_LEN + 1);
  localparam int HOLD_W = $clog2(DONE_HOLD + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    duty_q, duty_d;
  logic [LVL_W-1:0]    pwr_q, pwr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                startn_q, startn_d;
  logic                startn_seen_q, startn_seen_d;
  logic                mag_on_q, mag_on_d;
  logic                set_q, set_d;
  logic                reset_q, reset_d;
  logic                start_evt;
  logic                enter_cook;

  // A start needs a genuine 1->0 edge seen after reset; startn_seen_q blocks
  // the phantom edge of a button already held low when reset releases.
  assign start_evt = startn_q & startn_seen_q & ~startn;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    duty_d        = duty_q;
    pwr_d         = pwr_q;
    startn_d      = startn;
    startn_seen_d = startn_seen_q | startn;

    if (!clearn) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt && door_closed && !timer_done) state_d = COOKING;
        end
        COOKING: begin
          if (!door_closed || !stopn) begin
            state_d = PAUSED;
          end else if (timer_done) begin
            state_d = DONE;
            hold_d  = HOLD_W'(DONE_HOLD - 1);
          end
        end
        PAUSED: begin
          if (door_closed && stopn) begin
            if (timer_done) begin
              state_d = DONE;
              hold_d  = HOLD_W'(DONE_HOLD - 1);
            end else if (start_evt) begin
              state_d = COOKING;
            end
          end
        end
        DONE: begin
          if (!door_closed || hold_q == '0) state_d = IDLE;
          else                              hold_d  = hold_q - HOLD_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    enter_cook = (state_d == COOKING) && (state_q != COOKING);

    if (enter_cook) begin
      duty_d = '0;
      if (int'(pwr_level) >= CYCLE_LEN) pwr_d = LVL_W'(CYCLE_LEN);
      else                              pwr_d = LVL_W'(pwr_level);
    end else if (state_d == COOKING) begin
      if (int'(duty_q) == CYCLE_LEN - 1) duty_d = '0;
      else                               duty_d = duty_q + CNT_W'(1);
    end

    mag_on_d = (state_d == COOKING) && (int'(duty_d) < int'(pwr_d));
    set_d    = enter_cook;
    reset_d  = (state_q == COOKING) && (state_d != COOKING);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      duty_q        <= '0;
      pwr_q         <= '0;
      hold_q        <= '0;
      startn_q      <= 1'b1;
      startn_seen_q <= 1'b0;
      mag_on_q      <= 1'b0;
      set_q         <= 1'b0;
      reset_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      pwr_q         <= pwr_d;
      hold_q        <= hold_d;
      startn_q      <= startn_d;
      startn_seen_q <= startn_seen_d;
      mag_on_q      <= mag_on_d;
      set_q         <= set_d;
      reset_q       <= reset_d;
    end
  end

  assign state  = state_q;
  assign mag_on = mag_on_q;
  assign set    = set_q;
  assign reset  = reset_q;
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_controle_mag_pot.sv
// Directed bench for controle_mag_pot: stimulus pushes the expected output
// vector for each clock into a scoreboard; a negedge monitor pops and compares.
module tb_controle_mag_pot;

  logic       clk;
  logic       rst;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       timer_done;
  logic [3:0] pwr_level;
  logic       mag_on;
  logic       set;
  logic       reset;
  logic [1:0] state;
  logic       done;

  controle_mag_pot #(
    .PWR_W    (4),
    .CYCLE_LEN(10),
    .DONE_HOLD(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .pwr_level  (pwr_level),
    .mag_on     (mag_on),
    .set        (set),
    .reset      (reset),
    .state      (state),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {state[1:0], mag_on, set, reset, done}
  typedef struct {
    int         cyc;
    string      name;
    logic [5:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         cyc_cnt = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       mon_e;
  logic [5:0] mon_got;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e   = sb.pop_front();
      mon_got = {state, mag_on, set, reset, done};
      n_checks++;
      if (mon_e.cyc == cyc_cnt && mon_got === mon_e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s cyc=%0d: got {st,mag,set,rst,done}=%b_%b%b%b%b want %b_%b%b%b%b (due cyc %0d)",
                 mon_e.name, cyc_cnt, mon_got[5:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                 mon_e.exp[5:4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1], mon_e.exp[0], mon_e.cyc);
      end
    end
  end

  // One clock: queue the outputs expected after the next edge, then take it.
  task automatic tick(input string nm, input logic [1:0] st, input logic mg,
                      input logic s, input logic r);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.name = nm;
    e.exp  = {st, mg, s, r, (st == 2'd3)};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    timer_done  = 1'b0;
    pwr_level   = 4'd4;
    @(posedge clk);
    #1;
    tick("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // 1: power 4 -> 4 on / 6 off, three periods
    startn = 1'b0;
    tick("t1_set", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    for (int i = 1; i < 30; i++) tick("t1_duty", 2'd1, ((i % 10) < 4), 1'b0, 1'b0);
    clearn = 1'b0;
    tick("t1_clear", 2'd0, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;

    // 2: power 10 then 15 -> continuous on; mid-cook pwr change ignored
    pwr_level = 4'd10;
    startn = 1'b0;
    tick("t2_set10", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    pwr_level = 4'd0;
    for (int i = 1; i < 13; i++) tick("t2_on10", 2'd1, 1'b1, 1'b0, 1'b0);
    clearn = 1'b0;
    tick("t2_clear", 2'd0, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;
    tick("t2_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    pwr_level = 4'd15;
    startn = 1'b0;
    tick("t2_set15", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    for (int i = 1; i < 13; i++) tick("t2_on15", 2'd1, 1'b1, 1'b0, 1'b0);

    // 3: door open -> PAUSED; resume relatches power and restarts count
    door_closed = 1'b0;
    tick("t3_door", 2'd2, 1'b0, 1'b0, 1'b1);
    door_closed = 1'b1;
    pwr_level = 4'd4;
    tick("t3_paused", 2'd2, 1'b0, 1'b0, 1'b0);
    startn = 1'b0;
    tick("t3_resume", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    for (int i = 1; i < 10; i++) tick("t3_duty", 2'd1, (i < 4), 1'b0, 1'b0);

    // 4: startn held low: one set only, no restart from PAUSED
    clearn = 1'b0;
    tick("t4_clear", 2'd0, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;
    startn = 1'b0;
    tick("t4_set", 2'd1, 1'b1, 1'b1, 1'b0);
    tick("t4_cook", 2'd1, 1'b1, 1'b0, 1'b0);
    stopn = 1'b0;
    tick("t4_stop", 2'd2, 1'b0, 1'b0, 1'b1);
    stopn = 1'b1;
    for (int i = 0; i < 18; i++) tick("t4_held", 2'd2, 1'b0, 1'b0, 1'b0);
    startn = 1'b1;
    tick("t4_release", 2'd2, 1'b0, 1'b0, 1'b0);
    startn = 1'b0;
    tick("t4_resume", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;

    // 5: timer done -> DONE for 8 clocks, start ignored; then door-open abort
    timer_done = 1'b1;
    tick("t5_done", 2'd3, 1'b0, 1'b0, 1'b1);
    timer_done = 1'b0;
    for (int j = 1; j < 8; j++) begin
      startn = (j == 2) ? 1'b0 : 1'b1;
      tick("t5_hold", 2'd3, 1'b0, 1'b0, 1'b0);
    end
    startn = 1'b1;
    tick("t5_expire", 2'd0, 1'b0, 1'b0, 1'b0);
    startn = 1'b0;
    tick("t5_set", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    timer_done = 1'b1;
    tick("t5_done2", 2'd3, 1'b0, 1'b0, 1'b1);
    timer_done = 1'b0;
    tick("t5_hold2", 2'd3, 1'b0, 1'b0, 1'b0);
    door_closed = 1'b0;
    tick("t5_dooropen", 2'd0, 1'b0, 1'b0, 1'b0);
    door_closed = 1'b1;
    tick("t5_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // 6: simultaneous clear/door/timer, then reset mid-cook with startn low
    startn = 1'b0;
    tick("t6_set", 2'd1, 1'b1, 1'b1, 1'b0);
    startn = 1'b1;
    tick("t6_cook", 2'd1, 1'b1, 1'b0, 1'b0);
    clearn = 1'b0;
    door_closed = 1'b0;
    timer_done = 1'b1;
    tick("t6_simul", 2'd0, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;
    door_closed = 1'b1;
    timer_done = 1'b0;
    tick("t6_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    startn = 1'b0;
    tick("t6_set2", 2'd1, 1'b1, 1'b1, 1'b0);
    tick("t6_cook2", 2'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick("t6_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    tick("t6_rst_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("t6_no_start", 2'd0, 1'b0, 1'b0, 1'b0);
    startn = 1'b1;
    tick("t6_release", 2'd0, 1'b0, 1'b0, 1'b0);

    // Power 0: cooking but magnetron never on
    pwr_level = 4'd0;
    startn = 1'b0;
    tick("pwr0_set", 2'd1, 1'b0, 1'b1, 1'b0);
    startn = 1'b1;
    for (int i = 1; i < 12; i++) tick("pwr0_cook", 2'd1, 1'b0, 1'b0, 1'b0);
    clearn = 1'b0;
    tick("pwr0_clear", 2'd0, 1'b0, 1'b0, 1'b1);
    clearn = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
